clk_fanout_gen: RTL
===================

Name: clk_fanout_gen

Overview:
- Parametrised multi-channel fabric clock generator; successor to the fixed four-output, single-enable divided-clock fan-out.
- Produces N_CH square-wave clocks from the core clock, each with its own enable and a runtime-programmable half-period.
- Outputs are glitch-free; start/stop and divider changes happen only at period boundaries.
- Sits between the DCM output domain and the ASIC-chain clock pins; clk_o feeds output DDR/IOB registers.

Parameters:
- N_CH, 4, number of output clock channels (1-16).
- DIV_W, 8, width of half-period count.
- HALF_RST, 1, half-period in clk cycles loaded at reset (1 gives clk/2).
- STAGGER_CYC, 2, per-channel start offset in clk cycles (used only with CLKGEN_STAGGER_EN).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- en_i  in  N_CH  per-channel run request, level.
- half_i  in  DIV_W  new half-period in clk cycles; 0 is treated as 1.
- upd_i  in  1  one-cycle pulse; captures half_i into the shadow register.
- clk_o  out  N_CH  generated clocks, registered.
- run_o  out  N_CH  channel running (state is not IDLE).
- busy_o  out  1  update pending on at least one channel.

Behaviour:
- Reset, async on rst_n low: clk_o=0, run_o=0, busy_o=0, all channels IDLE, shadow and active half = HALF_RST, pend=0.
- Shadow capture: upd_i=1 latches max(half_i,1) into shadow and sets pend[i]=1 for all channels. An upd_i while pend is set overwrites the shadow; the last value wins.
- Per-channel active half register: copied from shadow, clearing pend[i], at that channel's commit points only:
  - IDLE to start transition.
  - End of LOW phase.
  - Any cycle in IDLE.
- busy_o = OR of pend.
- Per-channel FSM:
  - IDLE: clk_o=0. If en_i[i], go to HIGH with cnt=active-1.
  - HIGH: clk_o=1. When cnt=0, go to LOW with cnt=active-1; otherwise decrement.
  - LOW: clk_o=0. When cnt=0: if en_i[i], go to HIGH with cnt=newactive-1; else go to IDLE. Otherwise decrement.
- Latency: en_i rising at cycle t gives clk_o high at t+1 (registered). Period = 2*active cycles, duty cycle 50%.
- Stop: deassertion in HIGH or LOW never truncates. The channel completes the current full period, then idles low.
- Re-enable during the final LOW cycle continues seamlessly with no gap.
- Simultaneous upd_i and a commit point on the same cycle: the channel commits the old shadow. The new value stays pending and applies at the next boundary.
- half_i=0 with upd_i behaves identically to half_i=1.
- rst_n asserted mid-period forces clk_o low immediately (async). This is accepted as the only truncation case.
- Channels are independent. Clocks from channels with equal active half and simultaneous enable are cycle-aligned.

Optional Feature:
- CLKGEN_STAGGER_EN defined:
  - Adds a WAIT state between IDLE and HIGH.
  - Channel i loads cnt=i*STAGGER_CYC on enable and holds clk_o=0, run_o=1 until cnt=0, then enters HIGH.
  - Channel 0 waits 0 cycles, so it enters HIGH directly.
  - Dropping en_i during WAIT returns the channel to IDLE.
  - Purpose: spreads simultaneous turn-on current of the chain loads.
- CLKGEN_STAGGER_EN undefined: no WAIT state, and STAGGER_CYC is ignored.

Decomposition:
- Shared package holds:
  - FSM state encoding localparams: IDLE, HIGH, LOW, WAIT.
  - DIV_W default and the HALF_RST default.
- One natural sub-module, clk_fanout_ch: single-channel FSM, counter, active register and pend bit.
- The top instantiates N_CH copies in a generate loop and owns the shadow register, upd_i capture and busy_o OR.

Test Plan:
- Reset then en_i=4'b1111, HALF_RST=1 -> all clk_o toggle every cycle, aligned, first high at cycle 1 after enable; run_o=4'b1111.
- upd_i with half_i=3 while running -> busy_o=1 until each channel ends its current LOW. Then each channel shows high 3/low 3, and no pulse is shorter than 1 cycle.
- en_i[2] dropped mid-HIGH with half=4 -> clk_o[2] completes the remaining high and 4 low cycles, then stays 0; run_o[2]=0 the cycle after returning to IDLE.
- half_i=0 with upd_i -> behaviour identical to half=1; upd_i coincident with a LOW end -> the old value is used for one more period.
- rst_n low mid-HIGH -> clk_o=0, run_o=0, busy_o=0 immediately. After release, half=HALF_RST.
- CLKGEN_STAGGER_EN, STAGGER_CYC=2, en_i=4'b1111 -> first clk_o high on channels 0/1/2/3 at cycles 1/3/5/7 after enable.

Source files
------------

// File: rtl/clk_fanout_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clk_fanout_gen_pkg
// Purpose  : Shared definitions for the multi-channel fabric clock generator:
//            per-channel FSM state encoding, parameter defaults and a small
//            integer helper used for counter sizing.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package clk_fanout_gen_pkg;

  localparam int N_CH_DEF        = 4;
  localparam int DIV_W_DEF       = 8;
  localparam int HALF_RST_DEF    = 1;
  localparam int STAGGER_CYC_DEF = 2;

  // Per-channel FSM states. ST_WAIT is only reachable when the staggered
  // start option (CLKGEN_STAGGER_EN) is compiled in.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_WAIT = 2'd3
  } ch_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_fanout_ch.sv
`default_nettype none
// ============================================================================
// Module   : clk_fanout_ch
// Purpose  : One generated clock channel: IDLE/HIGH/LOW(/WAIT) FSM, phase
//            counter, active half-period register and update-pending bit.
//            The active half-period is refreshed from the shared shadow only
//            at period boundaries (any IDLE cycle, end of LOW), so a divider
//            change never produces a short pulse.
// Config   : CLKGEN_STAGGER_EN adds a WAIT state of WAIT_CYC cycles before
//            the first HIGH phase.
// Ports    : clk, rst_n      - core clock, async active-low reset
//            en             - run request (level)
//            shadow_half    - shared shadow half-period (always >= 1)
//            upd            - shadow is being rewritten this cycle
//            ch_clk         - generated clock (registered)
//            ch_run         - channel not idle (registered)
//            ch_pend        - shadow value not yet committed by this channel
// Revision : 1.0 - initial release
// ============================================================================
module clk_fanout_ch
  import clk_fanout_gen_pkg::*;
#(
  parameter int DIV_W    = DIV_W_DEF,
  parameter int HALF_RST = HALF_RST_DEF,
  parameter int WAIT_CYC = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] shadow_half,
  input  logic             upd,
  output logic             ch_clk,
  output logic             ch_run,
  output logic             ch_pend
);

  localparam int WAIT_W = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
  localparam int CNT_W  = max_int(DIV_W, WAIT_W);

  ch_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] active, active_nxt;
  logic             pend_nxt;
  logic             commit;
  logic [CNT_W-1:0] shadow_m1, active_m1;

  assign shadow_m1 = CNT_W'(shadow_half) - CNT_W'(1);
  assign active_m1 = CNT_W'(active) - CNT_W'(1);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    active_nxt = active;
    commit     = 1'b0;
    case (state)
      ST_IDLE: begin
        // Idle cycles keep the active half tracking the shadow, and a start
        // uses that same freshly committed value for its first HIGH phase.
        commit     = 1'b1;
        active_nxt = shadow_half;
        if (en) begin
`ifdef CLKGEN_STAGGER_EN
          if (WAIT_CYC == 0) begin
            state_nxt = ST_HIGH;
            cnt_nxt   = shadow_m1;
          end else begin
            // Counting down to zero inclusive makes WAIT last WAIT_CYC cycles.
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_W'(WAIT_CYC - 1);
          end
`else
          state_nxt = ST_HIGH;
          cnt_nxt   = shadow_m1;
`endif
        end
      end
`ifdef CLKGEN_STAGGER_EN
      ST_WAIT: begin
        if (!en) begin
          state_nxt = ST_IDLE;
        end else if (cnt == '0) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = active_m1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
`endif
      ST_HIGH: begin
        if (cnt == '0) begin
          state_nxt = ST_LOW;
          cnt_nxt   = active_m1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_LOW: begin
        if (cnt == '0) begin
          // Period boundary: enable is only sampled here, so a stop request
          // always lets the current period finish.
          commit     = 1'b1;
          active_nxt = shadow_half;
          if (en) begin
            state_nxt = ST_HIGH;
            cnt_nxt   = shadow_m1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    // A shadow write coinciding with a commit leaves the new value pending:
    // the commit above used the shadow as it was before this write.
    pend_nxt = upd | (ch_pend & ~commit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      active  <= DIV_W'(HALF_RST);
      ch_pend <= 1'b0;
      ch_clk  <= 1'b0;
      ch_run  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      active  <= active_nxt;
      ch_pend <= pend_nxt;
      // Dedicated output flops so the pins never see FSM decode glitches.
      ch_clk  <= (state_nxt == ST_HIGH);
      ch_run  <= (state_nxt != ST_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_fanout_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_fanout_gen
// Purpose  : N_CH-channel glitch-free divided clock fan-out. Each channel
//            has its own enable; all share one runtime-programmable
//            half-period held in a shadow register and adopted by each
//            channel at its own period boundary.
// Config   : CLKGEN_STAGGER_EN - channel i delays its first HIGH phase by
//            i*STAGGER_CYC cycles after enable.
// Ports    : clk     in  1      core clock
//            rst_n   in  1      async active-low reset
//            en_i    in  N_CH   per-channel run request
//            half_i  in  DIV_W  new half-period (0 treated as 1)
//            upd_i   in  1      capture half_i into the shadow
//            clk_o   out N_CH   generated clocks (registered)
//            run_o   out N_CH   channel running
//            busy_o  out 1      update pending on some channel
// Revision : 1.0 - initial release
// ============================================================================
module clk_fanout_gen
  import clk_fanout_gen_pkg::*;
#(
  parameter int N_CH        = N_CH_DEF,
  parameter int DIV_W       = DIV_W_DEF,
  parameter int HALF_RST    = HALF_RST_DEF,
  parameter int STAGGER_CYC = STAGGER_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  en_i,
  input  logic [DIV_W-1:0] half_i,
  input  logic             upd_i,
  output logic [N_CH-1:0]  clk_o,
  output logic [N_CH-1:0]  run_o,
  output logic             busy_o
);

`ifdef CLKGEN_STAGGER_EN
  localparam int STAG_STEP = STAGGER_CYC;
`else
  // Stagger disabled: every channel starts on the cycle after enable.
  localparam int STAG_STEP = 0 * STAGGER_CYC;
`endif

  logic [DIV_W-1:0] shadow;
  logic [N_CH-1:0]  pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= DIV_W'(HALF_RST);
    end else if (upd_i) begin
      shadow <= (half_i == '0) ? DIV_W'(1) : half_i;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clk_fanout_ch #(
      .DIV_W    (DIV_W),
      .HALF_RST (HALF_RST),
      .WAIT_CYC (i * STAG_STEP)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en_i[i]),
      .shadow_half (shadow),
      .upd         (upd_i),
      .ch_clk      (clk_o[i]),
      .ch_run      (run_o[i]),
      .ch_pend     (pend[i])
    );
  end

  assign busy_o = |pend;

endmodule
`default_nettype wire
